arr_mem_ctl: RTL

Parametrised, owner-arbitrated single-port array memory for synthesised kernels. It replaces the fixed one-entry, 64-bit array with a two-client wrapper: the kernel state machine and the host control port. An explicit request/grant handshake arbitrates between them, and a built-in clear engine zeroes the array. The block sits beside each kernel FSM, one instance per source-level array.

---
 rtl/arr_pkg.sv | 18 +
 rtl/arr_ram.sv | 27 ++
 rtl/arr_mem_ctl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/arr_pkg.sv
// Shared types and helpers for the owner-arbitrated array memory.
package arr_pkg;

  typedef enum logic [1:0] {
    KERN  = 2'd0,
    HOST  = 2'd1,
    CLEAR = 2'd2
  } owner_e;

  // Address width for n words, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/arr_ram.sv
// Single-port RAM: one write or one read per cycle, registered read address,
// storage is never reset.
module arr_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr_q;

  // Write the addressed word, or capture the read address for next cycle.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
    if (en && !we) rd_addr_q <= addr;
  end

  assign rdata = mem[rd_addr_q];

endmodule

// File: rtl/arr_mem_ctl.sv
// Two-client wrapper around one array: kernel FSM and host port share the
// RAM through an owner FSM, with a clear engine that zeroes every word.
//
//   state | meaning
//   KERN  | kernel owns the array (reset state)
//   HOST  | host owns the array, host_grant high
//   CLEAR | clear engine writes 0 to one address per cycle
module arr_mem_ctl
  import arr_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  output logic              host_grant,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              kern_busy,
  input  logic              kern_we,
  input  logic [ADDR_W-1:0] kern_addr,
  input  logic [DATA_W-1:0] kern_wdata,
  output logic [DATA_W-1:0] kern_rdata,
  output logic              kern_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  owner_e            state_q, state_d;
  logic              clr_pend_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              clr_done_q;
  logic              rd_kern_q, rd_host_q, rd_oor_q;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_oor;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_data;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // Owner selection and request mux; the host has priority over a pending clear.
  always_comb begin
    state_d   = state_q;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state_q)
      KERN: begin
        req_we    = kern_we;
        req_addr  = kern_addr;
        req_wdata = kern_wdata;
        if (host_req && !kern_busy)        state_d = HOST;
        else if (clr_pend_q && !kern_busy) state_d = CLEAR;
      end
      HOST: begin
        req_we    = host_we;
        req_addr  = host_addr;
        req_wdata = host_wdata;
        if (!host_req) state_d = KERN;
      end
      CLEAR: begin
        req_we    = 1'b1;
        req_addr  = clr_cnt_q;
        req_wdata = '0;
        if (clr_cnt_q == LAST) state_d = KERN;
      end
      default: state_d = KERN;
    endcase
  end

  assign req_oor = !in_range(req_addr);

  arr_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (!req_oor),
    .we    (req_we),
    .addr  (req_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  // Owner state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= KERN;
    else     state_q <= state_d;
  end

  // Sticky clear request: dropped on entry to CLEAR, ignored while clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       clr_pend_q <= 1'b0;
    else if (state_q == KERN && state_d == CLEAR)  clr_pend_q <= 1'b0;
    else if (clr_start && state_q != CLEAR)        clr_pend_q <= 1'b1;
  end

  // Clear address counter; wraps to 0 after the last word so the next run starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= (state_q == CLEAR) && (clr_cnt_q == LAST);
      if (state_q == CLEAR) clr_cnt_q <= (clr_cnt_q == LAST) ? '0 : clr_cnt_q + 1'b1;
    end
  end

  // Remember which port issued this cycle's read so data returns to it next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_kern_q <= 1'b0;
      rd_host_q <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      rd_kern_q <= (state_q == KERN) && !kern_we;
      rd_host_q <= (state_q == HOST) && !host_we;
      rd_oor_q  <= req_oor;
    end
  end

  assign rd_data     = rd_oor_q ? '0 : ram_rdata;
  assign kern_rdata  = rd_kern_q ? rd_data : '0;
  assign kern_rvalid = rd_kern_q;
  assign host_rdata  = rd_host_q ? rd_data : '0;
  assign host_rvalid = rd_host_q;
  assign host_grant  = (state_q == HOST);
  assign clr_busy    = (state_q == CLEAR);
  assign clr_done    = clr_done_q;

endmodule
